sccb_cfg_sequencer: RTL and testbench

- Sequential engine that walks a combinational register-configuration LUT and issues each entry as an SCCB/I2C register write to the camera through the existing bus master's command/response handshake.
- Generalises the fixed 8-bit-address/8-bit-data table to parametrised address and data widths (OV7670 8/8, OV5640-class 16/8).
- Adds power-up wait, in-table delay entries, optional read-back verify, bounded retry, and error reporting.
- Sits between the camera configuration LUT and the SCCB master, below the top-level camera init controller.

---
 rtl/sccb_cfg_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sccb_cfg_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_sequencer.sv
// Camera register-configuration sequencer: walks the LUT and issues each entry
// as an SCCB write, with power-up wait, delay entries, read-back verify and retry.
module sccb_cfg_sequencer #(
    parameter int         ADDR_W       = 8,
    parameter int         DATA_W       = 8,
    parameter int         IDX_W        = 8,
    parameter int         LUT_START    = 2,
    parameter int         LUT_DEPTH    = 165,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         POWERUP_WAIT = 50000,
    parameter int         DELAY_UNIT   = 50000,
    parameter int         MAX_RETRY    = 3,
    parameter int         VERIFY       = 0
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     start,
    output logic [IDX_W-1:0]         lut_index,
    input  logic [ADDR_W+DATA_W-1:0] lut_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     cmd_rd,
    output logic [7:0]               cmd_dev,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [DATA_W-1:0]        cmd_wdata,
    input  logic                     rsp_valid,
    input  logic                     rsp_err,
    input  logic [DATA_W-1:0]        rsp_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [IDX_W-1:0]         err_index,
    output logic [3:0]               retry_cnt
);

    localparam longint unsigned DLY_MAX =
        ((64'd1 << DATA_W) - 64'd1) * 64'(DELAY_UNIT);
    localparam longint unsigned CNT_MAX =
        (DLY_MAX > 64'(POWERUP_WAIT)) ? DLY_MAX : 64'(POWERUP_WAIT);
    localparam int CNT_W = $clog2(CNT_MAX + 64'd2);
    localparam logic [IDX_W-1:0] FIRST = IDX_W'(LUT_START);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(LUT_START + LUT_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PWR_WAIT, S_FETCH, S_WR_REQ, S_WR_WAIT, S_RD_REQ,
        S_RD_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   erri_q, erri_d;
    logic               fail;

    logic [ADDR_W-1:0]  lut_addr;
    logic [DATA_W-1:0]  lut_wdata;

    assign lut_addr  = lut_data[ADDR_W+DATA_W-1:DATA_W];
    assign lut_wdata = lut_data[DATA_W-1:0];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            idx_q   <= FIRST;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            erri_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            erri_q  <= erri_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        erri_d  = erri_q;
        fail    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_PWR_WAIT;
                    idx_d   = FIRST;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    retry_d = '0;
                    cnt_d   = CNT_W'(POWERUP_WAIT);
                end
            end
            // A count of 0 or 1 both leave after a single cycle
            S_PWR_WAIT: begin
                if (cnt_q <= CNT_W'(1)) state_d = S_FETCH;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_FETCH: begin
                addr_d = lut_addr;
                data_d = lut_wdata;
                if (&lut_addr) begin
                    state_d = S_DELAY;
                    cnt_d   = CNT_W'(lut_wdata) * CNT_W'(DELAY_UNIT);
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (cmd_ready) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_err) fail = 1'b1;
                    else if (VERIFY != 0) state_d = S_RD_REQ;
                    else state_d = S_NEXT;
                end
            end
            S_RD_REQ: begin
                if (cmd_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_err || rsp_rdata != data_q) fail = 1'b1;
                    else state_d = S_NEXT;
                end
            end
            S_DELAY: begin
                if (cnt_q <= CNT_W'(1)) state_d = S_NEXT;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_NEXT: begin
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_FETCH;
                    idx_d   = idx_q + IDX_W'(1);
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A failed write or read-back re-writes the same entry
        if (fail) begin
            if (retry_q < 4'(MAX_RETRY)) begin
                retry_d = retry_q + 4'd1;
                state_d = S_WR_REQ;
            end else begin
                state_d = S_ERROR;
                erri_d  = idx_q;
                error_d = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    assign lut_index = idx_q;
    assign cmd_valid = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign cmd_rd    = (state_q == S_RD_REQ);
    assign cmd_dev   = DEV_ADDR | {7'b0, cmd_rd};
    assign cmd_addr  = addr_q;
    assign cmd_wdata = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = erri_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: a plain-write instance (8-bit address) and a
// read-back-verify instance (16-bit address) driven by one randomized SCCB master.
module tb_sccb_cfg_sequencer;

    localparam int PWR   = 4;
    localparam int UNIT  = 8;
    localparam int DEPTH = 6;
    localparam int FIRST = 2;
    localparam int MAXR  = 2;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        start = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_err = 1'b0;
    logic [7:0]  rsp_rdata = 8'h00;
    int          sel = 0;

    logic [23:0] lut_mem [256];
    logic [15:0] e_addr [DEPTH];
    logic [7:0]  e_data [DEPTH];
    int          out_q[$];
    int          bp_q[$];
    int          lat_fix = -1;
    int          n_chk = 0;
    int          n_err = 0;

    logic        start0, valid0, rd0, busy0, done0, error0;
    logic [7:0]  idx0, dev0, addr0, wdata0, erri0;
    logic [15:0] lut_data0;
    logic [3:0]  retry0;
    logic        start1, valid1, rd1, busy1, done1, error1;
    logic [7:0]  idx1, dev1, wdata1, erri1;
    logic [15:0] addr1;
    logic [23:0] lut_data1;
    logic [3:0]  retry1;

    logic        cur_valid, cur_rd, cur_busy, cur_done, cur_error;
    logic [7:0]  cur_idx, cur_dev, cur_wdata, cur_erri;
    logic [15:0] cur_addr;
    logic [3:0]  cur_retry;

    assign start0    = start && (sel == 0);
    assign start1    = start && (sel == 1);
    assign lut_data0 = lut_mem[idx0][15:0];
    assign lut_data1 = lut_mem[idx1];

    sccb_cfg_sequencer #(
        .ADDR_W(8), .DATA_W(8), .IDX_W(8), .LUT_START(FIRST),
        .LUT_DEPTH(DEPTH), .DEV_ADDR(8'h42), .POWERUP_WAIT(PWR),
        .DELAY_UNIT(UNIT), .MAX_RETRY(MAXR), .VERIFY(0)
    ) u_wr (
        .iCLK(iCLK), .iRST_N(iRST_N), .start(start0),
        .lut_index(idx0), .lut_data(lut_data0),
        .cmd_valid(valid0), .cmd_ready(cmd_ready), .cmd_rd(rd0),
        .cmd_dev(dev0), .cmd_addr(addr0), .cmd_wdata(wdata0),
        .rsp_valid(rsp_valid && sel == 0), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .busy(busy0), .done(done0),
        .error(error0), .err_index(erri0), .retry_cnt(retry0)
    );

    sccb_cfg_sequencer #(
        .ADDR_W(16), .DATA_W(8), .IDX_W(8), .LUT_START(FIRST),
        .LUT_DEPTH(DEPTH), .DEV_ADDR(8'h42), .POWERUP_WAIT(PWR),
        .DELAY_UNIT(UNIT), .MAX_RETRY(MAXR), .VERIFY(1)
    ) u_vf (
        .iCLK(iCLK), .iRST_N(iRST_N), .start(start1),
        .lut_index(idx1), .lut_data(lut_data1),
        .cmd_valid(valid1), .cmd_ready(cmd_ready), .cmd_rd(rd1),
        .cmd_dev(dev1), .cmd_addr(addr1), .cmd_wdata(wdata1),
        .rsp_valid(rsp_valid && sel == 1), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .busy(busy1), .done(done1),
        .error(error1), .err_index(erri1), .retry_cnt(retry1)
    );

    always_comb begin
        if (sel == 0) begin
            cur_valid = valid0; cur_rd = rd0; cur_dev = dev0;
            cur_addr = {8'h00, addr0}; cur_wdata = wdata0;
            cur_busy = busy0; cur_done = done0; cur_error = error0;
            cur_idx = idx0; cur_erri = erri0; cur_retry = retry0;
        end else begin
            cur_valid = valid1; cur_rd = rd1; cur_dev = dev1;
            cur_addr = addr1; cur_wdata = wdata1;
            cur_busy = busy1; cur_done = done1; cur_error = error1;
            cur_idx = idx1; cur_erri = erri1; cur_retry = retry1;
        end
    end

    always #5 iCLK = ~iCLK;

    initial begin
        #800000;
        $display("FAIL watchdog: got no end, need end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge iCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h (sel %0d, t=%0t)",
                     tag, got, exp, sel, $time);
        end
    endtask

    function automatic bit is_dly(input int i);
        if (sel == 0) return e_addr[i][7:0] == 8'hFF;
        return e_addr[i] == 16'hFFFF;
    endfunction

    function automatic int next_out(input int pct, input bit rd);
        if (out_q.size() > 0) return out_q.pop_front();
        if ($urandom_range(0, 99) < pct) return rd ? $urandom_range(1, 2) : 1;
        return 0;
    endfunction

    task automatic put(input int i, input logic [15:0] a,
                       input logic [7:0] d);
        e_addr[i] = a;
        e_data[i] = d;
    endtask

    task automatic rand_table();
        logic [15:0] m;
        m = (sel == 0) ? 16'h00FF : 16'hFFFF;
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                put(i, m, 8'($urandom_range(0, 3)));
            end else begin
                put(i, 16'($urandom) & m, 8'($urandom));
                if (e_addr[i] == m) e_data[i] &= 8'h03;
            end
        end
    endtask

    task automatic load_lut();
        for (int k = 0; k < 256; k++) lut_mem[k] = 24'($urandom);
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == 0) lut_mem[FIRST+i] = {8'h00, e_addr[i][7:0], e_data[i]};
            else lut_mem[FIRST+i] = {e_addr[i], e_data[i]};
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, cur_valid, 0);
        chk({tag, "_rd"}, cur_rd, 0);
        chk({tag, "_dev"}, cur_dev, 8'h42);
        chk({tag, "_addr"}, cur_addr, 0);
        chk({tag, "_wdata"}, cur_wdata, 0);
        chk({tag, "_busy"}, cur_busy, 0);
        chk({tag, "_done"}, cur_done, 0);
        chk({tag, "_error"}, cur_error, 0);
        chk({tag, "_erri"}, cur_erri, 0);
        chk({tag, "_retry"}, cur_retry, 0);
        chk({tag, "_idx"}, cur_idx, FIRST);
    endtask

    // Waits for valid (0), done (1) or error (2) while poking ignored inputs
    task automatic wait_for(input int kind, input int exp_n, input string tag);
        int n;
        bit hit;
        n = 0;
        forever begin
            start = 0; cmd_ready = 0; rsp_valid = 0; rsp_err = 0;
            hit = (kind == 0) ? cur_valid : (kind == 1) ? cur_done : cur_error;
            if (hit || n > exp_n + 50) break;
            start = ($urandom_range(0, 7) == 0);
            cmd_ready = ($urandom_range(0, 1) == 1);
            rsp_valid = ($urandom_range(0, 5) == 0);
            rsp_err = 1'($urandom_range(0, 1));
            rsp_rdata = 8'($urandom);
            tick();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic xact(input bit rd, input logic [15:0] a,
                        input logic [7:0] d, input bit err,
                        input logic [7:0] rdata);
        int bp, lat;
        bp = (bp_q.size() > 0) ? bp_q.pop_front() :
             (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 6);
        for (int k = 0; k < bp; k++) begin
            rsp_valid = ($urandom_range(0, 3) == 0);
            rsp_err = 1'($urandom_range(0, 1));
            tick();
            rsp_valid = 0; rsp_err = 0;
            chk("bp_valid", cur_valid, 1);
            chk("bp_addr", cur_addr, a);
            chk("bp_rd", cur_rd, rd);
            if (!rd) chk("bp_wdata", cur_wdata, d);
        end
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        chk("acc_drop", cur_valid, 0);
        repeat (lat) tick();
        rsp_valid = 1; rsp_err = err; rsp_rdata = rdata;
        tick();
        rsp_valid = 0; rsp_err = 0;
    endtask

    task automatic run(input int pct);
        int gap, retries, last_ret, out, i, n;
        bit aborted, ok;
        logic [15:0] a;
        logic [7:0] d;
        load_lut();
        start = 1;
        tick();
        start = 0;
        chk("go_busy", cur_busy, 1);
        chk("go_done", cur_done, 0);
        chk("go_error", cur_error, 0);
        chk("go_idx", cur_idx, FIRST);
        chk("go_retry", cur_retry, 0);
        gap = PWR + 1;
        aborted = 0;
        last_ret = 0;
        retries = 0;
        for (i = 0; i < DEPTH; i++) begin
            if (i > 0) last_ret = 0;
            a = e_addr[i];
            d = e_data[i];
            if (is_dly(i)) begin
                n = int'(d) * UNIT;
                gap += 2 + ((n > 1) ? n : 1);
                continue;
            end
            retries = 0;
            forever begin
                wait_for(0, gap, "wr_gap");
                gap = 0;
                chk("wr_rd", cur_rd, 0);
                chk("wr_dev", cur_dev, 8'h42);
                chk("wr_addr", cur_addr, a);
                chk("wr_data", cur_wdata, d);
                chk("wr_idx", cur_idx, FIRST + i);
                chk("wr_retry", cur_retry, retries);
                out = next_out(pct, 0);
                xact(0, a, d, out == 1, 8'($urandom));
                ok = (out == 0);
                if (ok && sel == 1) begin
                    wait_for(0, 0, "rd_gap");
                    chk("rd_rd", cur_rd, 1);
                    chk("rd_dev", cur_dev, 8'h43);
                    chk("rd_addr", cur_addr, a);
                    out = next_out(pct, 1);
                    xact(1, a, d, out == 1,
                         (out == 2) ? (d ^ 8'($urandom_range(1, 255))) : d);
                    ok = (out == 0);
                end
                if (ok) break;
                if (retries < MAXR) begin
                    retries++;
                    continue;
                end
                aborted = 1;
                break;
            end
            last_ret = retries;
            if (aborted) break;
            gap = 2;
        end
        if (aborted) begin
            wait_for(2, 0, "err_gap");
            chk("err_busy", cur_busy, 0);
            chk("err_done", cur_done, 0);
            chk("err_index", cur_erri, FIRST + i);
            chk("err_retry", cur_retry, MAXR);
            chk("err_idx", cur_idx, FIRST + i);
        end else begin
            wait_for(1, gap - 1, "done_gap");
            chk("done_busy", cur_busy, 0);
            chk("done_error", cur_error, 0);
            chk("done_retry", cur_retry, last_ret);
            chk("done_idx", cur_idx, FIRST + DEPTH - 1);
        end
        repeat (2) tick();
        out_q.delete();
        bp_q.delete();
        lat_fix = -1;
    endtask

    task automatic normal_table();
        put(0, 16'h0012, 8'h14); put(1, 16'h0040, 8'hd0);
        put(2, 16'h003a, 8'h04); put(3, 16'h0055, 8'h11);
        put(4, 16'h0066, 8'h22); put(5, 16'h0077, 8'h33);
    endtask

    initial begin
        repeat (2) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1 check_reset("rst");
        end
        iRST_N = 1;
        tick();

        sel = 0;
        normal_table();
        bp_q = '{0, 10};
        lat_fix = 5;
        run(0);

        normal_table();
        out_q = '{0, 1, 1, 1};
        run(0);

        normal_table();
        put(0, 16'h00ff, 8'h03);
        put(1, 16'h0000, 8'h00);
        run(0);

        sel = 1;
        normal_table();
        out_q = '{0, 2, 0, 0};
        run(0);

        sel = 0;
        normal_table();
        load_lut();
        start = 1;
        tick();
        start = 0;
        wait_for(0, PWR + 1, "ar_gap");
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        repeat (2) tick();
        #2 iRST_N = 0;
        #1 check_reset("arst");
        tick();
        tick();
        iRST_N = 1;
        check_reset("arst_hold");
        tick();
        run(0);

        for (int r = 0; r < 24; r++) begin
            sel = r % 2;
            rand_table();
            run((r % 3) * 25);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
